fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage, directly upstream of the decode stage.
- Owns the PC and issues one-at-a-time requests on the instruction bus.
- Buffers one returned instruction and presents it to decode as an if_id record.
- Handles redirects (branch/jump/trap/mret) and downstream stalls without losing or duplicating instructions.

Parameters:
- PC_RESET, 64'h8000_0000: PC value after reset.
- NOP_INST, 32'h0000_0013: instruction word placed in the record when a fetch traps.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- ireq_valid  out  1  instruction request valid.
- ireq_addr  out  64  request address; stable while ireq_valid=1 and iresp_data_ok=0.
- iresp_data_ok  in  1  response for the outstanding request is present this cycle.
- iresp_data  in  32  instruction word; valid only when iresp_data_ok=1.
- if_id_state  out  if_id  record to decode: inst, inst_pc, valid, inst_counter, trap.
- id_ready  in  1  decode consumes if_id_state this cycle if valid=1.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  64  restart target.

Behaviour:
- Reset is asynchronous, active-low. While reset_n=0:
  - pc=PC_RESET, state=FETCH, ireq_valid=0.
  - if_id_state.valid=0, inst=0, inst_pc=0, inst_counter=0, trap cleared.
- One-entry output buffer (outbuf).
  - outbuf "frees" this cycle if it is empty, or if it is valid and id_ready=1.
- States: FETCH, HOLD, DRAIN.
- FETCH:
  - If pc[1:0]!=0 (misaligned):
    - No request is issued.
    - On free: outbuf<={NOP_INST, pc, valid=1, trap_valid=1, trap_code=0, is_exception=1}.
    - Go to HOLD. pc is not advanced; only a redirect leaves this condition.
  - Otherwise, ireq_valid=1 and ireq_addr=pc while outbuf frees, or while a request is already outstanding.
    - A request, once raised, stays raised with the same address until data_ok.
  - On iresp_data_ok:
    - Next cycle outbuf holds {iresp_data, pc, valid=1, counter, trap cleared}.
    - pc<=pc+4 (64-bit wrap).
    - Stay in FETCH if outbuf freed this cycle, else go to HOLD.
  - Latency: output valid 1 cycle after data_ok.
  - Back-to-back throughput is 1 instruction per bus response.
- HOLD:
  - ireq_valid=0.
  - When id_ready=1, outbuf is consumed and state returns to FETCH.
  - A trapped record stays in HOLD until redirect.
- inst_counter:
  - Increments by 1 for each record loaded into outbuf, including trap records.
  - 64-bit, wraps.
  - Not incremented for discarded responses.
- Redirect (redirect_valid=1) has priority over all other events in that cycle:
  - outbuf.valid<=0 and pc<=redirect_pc.
  - If a request is outstanding with no data_ok this cycle: go to DRAIN. ireq stays asserted at the old address until data_ok; that response is dropped; then go to FETCH.
  - If data_ok arrives in the same cycle: the data is dropped; go to FETCH.
  - If no request is outstanding: go to FETCH.
  - A second redirect during DRAIN updates pc only; DRAIN continues.
- Reset mid-request:
  - The outstanding request is abandoned.
  - The bus must tolerate ireq_valid dropping.
- Record hold: if_id_state changes only when outbuf is loaded or on redirect/reset. It is held while valid=1 and id_ready=0.

Decomposition:
- Shared package (temp_storage / common):
  - fetch_state_t enum {FETCH, HOLD, DRAIN}.
  - Constants PC_RESET_DEFAULT and NOP_INST.
  - Trap code constant INST_ADDR_MISALIGNED=0, alongside ILLEGAL_INST code 2.
- Sub-module fetch_buffer: one-entry if_id register with load, consume, flush and free output.
- PC/state logic stays in fetch_stage.

Test Plan:
- Reset release, bus returns 0x00000013 two cycles after each request, id_ready=1:
  - Requests at 0x80000000, 0x80000004, 0x80000008.
  - Records carry inst_pc in the same order with inst_counter 0, 1, 2.
- id_ready=0 for 5 cycles after the first record:
  - if_id_state held unchanged; ireq_valid=0 once HOLD is entered.
  - On release, next request is at 0x80000004; no instruction is duplicated or dropped.
- redirect to 0x80001000 one cycle after a request to 0x80000004 is issued, data_ok 3 cycles later:
  - ireq_addr held at 0x80000004 until data_ok; that data is discarded.
  - Next request is at 0x80001000; inst_counter is not incremented for the dropped word.
- redirect and data_ok in the same cycle:
  - The word is dropped; valid=0 next cycle; next request is at redirect_pc.
- redirect to 0x80000002:
  - No ireq is issued.
  - Record {inst=0x00000013, inst_pc=0x80000002, trap_valid=1, trap_code=0} is held.
  - A subsequent redirect to 0x80000000 resumes normal fetch.
- reset_n pulled low while ireq_valid=1:
  - ireq_valid=0 and valid=0 immediately (asynchronous).
  - After release, fetch restarts at 0x80000000 with counter 0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: fetch FSM states, reset/NOP constants, trap codes and the if_id record layout
package fetch_stage_pkg;
  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} fetch_state_t;
  localparam logic [63:0] PC_RESET_DEFAULT = 64'h8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [3:0] INST_ADDR_MISALIGNED = 4'd0;
  localparam logic [3:0] ILLEGAL_INST = 4'd2;
  typedef struct packed {
    logic       trap_valid;
    logic [3:0] trap_code;
    logic       is_exception;
  } trap_t;
  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        valid;
    logic [63:0] inst_counter;
    trap_t       trap;
  } if_id_t;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: one-entry if_id register (load/load_rec fill, consume drains, flush drops valid, rec out, free = can take a load this cycle)
module fetch_buffer
  import fetch_stage_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   load,
  input  if_id_t load_rec,
  input  logic   consume,
  input  logic   flush,
  output if_id_t rec,
  output logic   free
);
  assign free = !rec.valid || consume;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rec <= '0;
    else if (flush) rec.valid <= 1'b0;
    else if (load) rec <= load_rec;
    else if (consume) rec.valid <= 1'b0;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC/FSM owner issuing one-at-a-time ireq_valid/ireq_addr, taking iresp_data_ok/iresp_data, presenting if_id_state to decode (id_ready), honouring redirect_valid/redirect_pc
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [63:0] PC_RESET = PC_RESET_DEFAULT,
  parameter logic [31:0] NOP_INST = fetch_stage_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output if_id_t      if_id_state,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc
);
  fetch_state_t state, state_nx;
  logic [63:0] pc, pc_nx, req_addr, cnt;
  logic pending, free, consume, load, mis, fire;
  if_id_t load_rec;
  assign mis = |pc[1:0];
  assign fire = ireq_valid && iresp_data_ok;
  // a trap record is never consumed; only a redirect clears it
  assign consume = id_ready && !if_id_state.trap.trap_valid;
  assign ireq_valid = reset_n && ((state == DRAIN) || (state == FETCH && !mis && (free || pending)));
  assign ireq_addr = pending ? req_addr : pc;
  assign load = !redirect_valid && state == FETCH && (mis ? free : fire);
  assign load_rec = mis ? if_id_t'{NOP_INST, pc, 1'b1, cnt, trap_t'{1'b1, INST_ADDR_MISALIGNED, 1'b1}}
                        : if_id_t'{iresp_data, pc, 1'b1, cnt, trap_t'{1'b0, 4'd0, 1'b0}};
  assign pc_nx = redirect_valid ? redirect_pc : (state == FETCH && fire) ? pc + 64'd4 : pc;
  always_comb
    state_nx = redirect_valid ? ((ireq_valid && !iresp_data_ok) ? DRAIN : FETCH)
             : state == DRAIN ? (iresp_data_ok ? FETCH : DRAIN)
             : state == HOLD  ? (consume ? FETCH : HOLD)
             : mis            ? (free ? HOLD : FETCH)
             : (fire && !free) ? HOLD : FETCH;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state    <= FETCH;
      pc       <= PC_RESET;
      cnt      <= '0;
      pending  <= 1'b0;
      req_addr <= '0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      pending  <= ireq_valid && !iresp_data_ok;
      req_addr <= ireq_addr;
      if (load) cnt <= cnt + 64'd1;
    end
  fetch_buffer u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .load_rec(load_rec),
    .consume (consume),
    .flush   (redirect_valid),
    .rec     (if_id_state),
    .free    (free)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized checks of fetch_stage against a transaction-level reference model
module tb_fetch_stage;
  import fetch_stage_pkg::*;
  logic clk = 1'b0, reset_n = 1'b0;
  logic ireq_valid, iresp_data_ok = 1'b0, id_ready = 1'b0, redirect_valid = 1'b0;
  logic [63:0] ireq_addr, redirect_pc = '0;
  logic [31:0] iresp_data = '0;
  if_id_t if_id_state;
  int n_tests = 0, n_fail = 0;
  if_id_t m_buf;
  logic [63:0] m_pc, m_cnt, m_addr;
  logic m_out, m_drop;
  int bus_age = 0, lat = 2;
  logic rand_lat = 1'b0, fixed_data = 1'b1;
  logic [63:0] fire_q[$];
  if_id_t rec_q[$];
  logic prev_v;
  logic [63:0] prev_c;
  fetch_stage dut (
    .clk(clk), .reset_n(reset_n), .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data), .if_id_state(if_id_state),
    .id_ready(id_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [63:0] fa(input int i);
    return i < fire_q.size() ? fire_q[i] : '1;
  endfunction
  function automatic if_id_t ra(input int i);
    return i < rec_q.size() ? rec_q[i] : '1;
  endfunction
  task automatic do_reset();
    reset_n = 1'b0;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    iresp_data_ok = 1'b0;
    redirect_pc = '0;
    #1;
    chk("reset ireq_valid", 200'(ireq_valid), 200'(0));
    chk("reset if_id_state", 200'(if_id_state), 200'(0));
    repeat (2) @(posedge clk);
    m_buf = '0;
    m_pc = 64'h8000_0000;
    m_cnt = '0;
    m_addr = '0;
    m_out = 1'b0;
    m_drop = 1'b0;
    bus_age = 0;
    fire_q.delete();
    rec_q.delete();
    prev_v = 1'b0;
    prev_c = '0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask
  // one clock: drive at the negedge, check 1ns later, advance the model at the posedge, return at the next negedge
  task automatic step(input logic rdy, input logic rv, input logic [63:0] rpc, input logic rv_on_ok);
    logic ok, req, fr, mis, trapped;
    logic [63:0] addr;
    if (rand_lat && bus_age == 0) lat = $urandom_range(1, 3);
    ok = bus_age != 0 && bus_age >= lat;
    iresp_data_ok = ok;
    iresp_data = fixed_data ? 32'h0000_0013 : $urandom;
    id_ready = rdy;
    redirect_valid = rv || (rv_on_ok && ok);
    redirect_pc = rpc;
    #1;
    trapped = m_buf.valid && m_buf.trap.trap_valid;
    fr = !m_buf.valid || (rdy && !trapped);
    mis = m_pc[1:0] != 2'b00;
    req = m_out || (!mis && !trapped && fr);
    addr = m_out ? m_addr : m_pc;
    chk("ireq_valid", 200'(ireq_valid), 200'(req));
    if (req) chk("ireq_addr", 200'(ireq_addr), 200'(addr));
    chk("if_id_state", 200'(if_id_state), 200'(m_buf));
    if (ireq_valid && iresp_data_ok) fire_q.push_back(ireq_addr);
    if (if_id_state.valid && (!prev_v || if_id_state.inst_counter != prev_c)) rec_q.push_back(if_id_state);
    prev_v = if_id_state.valid;
    prev_c = if_id_state.inst_counter;
    @(posedge clk);
    bus_age = (req && !ok) ? bus_age + 1 : 0;
    if (redirect_valid) begin
      m_buf.valid = 1'b0;
      m_pc = rpc;
      m_out = req && !ok;
      m_drop = m_out;
      m_addr = addr;
    end else if (req && ok) begin
      if (!m_drop) begin
        m_buf = if_id_t'{iresp_data, m_pc, 1'b1, m_cnt, trap_t'{1'b0, 4'd0, 1'b0}};
        m_cnt = m_cnt + 64'd1;
        m_pc = m_pc + 64'd4;
      end
      m_out = 1'b0;
      m_drop = 1'b0;
    end else begin
      if (req) begin
        m_out = 1'b1;
        m_addr = addr;
      end
      if (mis && !m_out && fr && !trapped) begin
        m_buf = if_id_t'{32'h0000_0013, m_pc, 1'b1, m_cnt, trap_t'{1'b1, 4'd0, 1'b1}};
        m_cnt = m_cnt + 64'd1;
      end else if (m_buf.valid && rdy && !trapped) m_buf.valid = 1'b0;
    end
    @(negedge clk);
  endtask
  initial begin
    if_id_t exp_rec;
    logic [63:0] tgt;
    do_reset();
    repeat (12) step(1, 0, 0, 0);
    chk("s1 fires", 200'(fire_q.size() >= 3), 200'(1));
    chk("s1 req0", 200'(fa(0)), 200'(64'h8000_0000));
    chk("s1 req1", 200'(fa(1)), 200'(64'h8000_0004));
    chk("s1 req2", 200'(fa(2)), 200'(64'h8000_0008));
    chk("s1 recs", 200'(rec_q.size() >= 3), 200'(1));
    for (int i = 0; i < 3; i++) begin
      chk("s1 rec pc", 200'(ra(i).inst_pc), 200'(64'h8000_0000 + 64'(4 * i)));
      chk("s1 rec cnt", 200'(ra(i).inst_counter), 200'(i));
      chk("s1 rec inst", 200'(ra(i).inst), 200'(32'h13));
    end
    do_reset();
    repeat (3) step(1, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0);
    chk("s2 hold ireq", 200'(ireq_valid), 200'(0));
    chk("s2 hold pc", 200'(if_id_state.inst_pc), 200'(64'h8000_0000));
    chk("s2 hold valid", 200'(if_id_state.valid), 200'(1));
    repeat (8) step(1, 0, 0, 0);
    chk("s2 next req", 200'(fa(1)), 200'(64'h8000_0004));
    chk("s2 rec1 pc", 200'(ra(1).inst_pc), 200'(64'h8000_0004));
    chk("s2 rec1 cnt", 200'(ra(1).inst_counter), 200'(1));
    do_reset();
    repeat (3) step(1, 0, 0, 0);
    lat = 4;
    step(1, 0, 0, 0);
    step(1, 1, 64'h8000_1000, 0);
    repeat (14) step(1, 0, 0, 0);
    chk("s3 held req", 200'(fa(1)), 200'(64'h8000_0004));
    chk("s3 new req", 200'(fa(2)), 200'(64'h8000_1000));
    chk("s3 rec1 pc", 200'(ra(1).inst_pc), 200'(64'h8000_1000));
    chk("s3 rec1 cnt", 200'(ra(1).inst_counter), 200'(1));
    lat = 2;
    do_reset();
    repeat (2) step(1, 0, 0, 0);
    step(1, 0, 64'h8000_2000, 1);
    chk("s4 valid", 200'(if_id_state.valid), 200'(0));
    chk("s4 ireq", 200'(ireq_valid), 200'(1));
    chk("s4 addr", 200'(ireq_addr), 200'(64'h8000_2000));
    repeat (6) step(1, 0, 0, 0);
    chk("s4 rec0 pc", 200'(ra(0).inst_pc), 200'(64'h8000_2000));
    chk("s4 rec0 cnt", 200'(ra(0).inst_counter), 200'(0));
    do_reset();
    step(1, 1, 64'h8000_0002, 0);
    repeat (10) step(1, 0, 0, 0);
    exp_rec = if_id_t'{32'h0000_0013, 64'h8000_0002, 1'b1, 64'd0, trap_t'{1'b1, 4'd0, 1'b1}};
    chk("s5 trap rec", 200'(if_id_state), 200'(exp_rec));
    chk("s5 no ireq", 200'(ireq_valid), 200'(0));
    chk("s5 fires", 200'(fire_q.size()), 200'(1));
    step(1, 1, 64'h8000_0000, 0);
    repeat (6) step(1, 0, 0, 0);
    chk("s5 resume pc", 200'(ra(1).inst_pc), 200'(64'h8000_0000));
    chk("s5 resume cnt", 200'(ra(1).inst_counter), 200'(1));
    chk("s5 resume trap", 200'(ra(1).trap.trap_valid), 200'(0));
    do_reset();
    step(1, 0, 0, 0);
    chk("s6 pre ireq", 200'(ireq_valid), 200'(1));
    #2 reset_n = 1'b0;
    #1;
    chk("s6 async ireq", 200'(ireq_valid), 200'(0));
    chk("s6 async valid", 200'(if_id_state.valid), 200'(0));
    do_reset();
    repeat (8) step(1, 0, 0, 0);
    chk("s6 restart req", 200'(fa(0)), 200'(64'h8000_0000));
    chk("s6 restart pc", 200'(ra(0).inst_pc), 200'(64'h8000_0000));
    chk("s6 restart cnt", 200'(ra(0).inst_counter), 200'(0));
    do_reset();
    rand_lat = 1'b1;
    fixed_data = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 9))
        0: tgt = 64'hFFFF_FFFF_FFFF_FFF0;
        1: tgt = 64'h8000_0000 + 64'($urandom_range(0, 255));
        default: tgt = 64'h8000_0000 + 64'($urandom_range(0, 255) * 4);
      endcase
      step($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0, tgt, $urandom_range(0, 7) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
